// File: rtl/q2b_seq_monitor_if.sv
// Handshake bundle for q2b_seq_monitor: stimulus inputs toward the monitor,
// status outputs back to whoever drives it.
interface q2b_seq_monitor_if #(
  parameter int CNT_W = 8
);
  logic             x;
  logic             y;
  logic             rearm;
  logic             f;
  logic             g;
  logic             granted;
  logic             denied;
  logic [CNT_W-1:0] grant_count;

  modport master (output x, y, rearm, input f, g, granted, denied, grant_count);
  modport slave  (input x, y, rearm, output f, g, granted, denied, grant_count);
endinterface

// File: rtl/q2b_seq_monitor.sv
// Pattern-triggered enable controller: start pulse, overlapping x-pattern
// search, y confirm window, GRANT/DENY lockout with rearm, grant counter.
module q2b_seq_monitor #(
  parameter int                 PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0] PAT     = 3'b101,
  parameter int                 Y_WIN   = 2,
  parameter int                 CNT_W   = 8
) (
  input logic            clk,
  input logic            resetn,
  q2b_seq_monitor_if.slave bus
);
  localparam int HW = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;
  localparam int VW = $clog2(PAT_LEN + 1);
  localparam int KW = (Y_WIN > 1) ? $clog2(Y_WIN) : 1;

  typedef enum logic [2:0] {RST, F_PULSE, SEARCH, WAIT_Y, GRANT, DENY} state_t;

  state_t             state, state_next;
  logic [HW-1:0]      hist;
  logic [VW-1:0]      vcnt;
  logic [KW-1:0]      k;
  logic [CNT_W-1:0]   cnt;
  logic [PAT_LEN-1:0] cand;
  logic               match;
  logic               k_last;

  generate
    if (PAT_LEN > 1) begin : g_cand
      assign cand = {hist[PAT_LEN-2:0], bus.x};
    end else begin : g_cand1
      assign cand = bus.x;
    end
  endgenerate

  // The count guard keeps stale zeros in history from matching early.
  assign match  = (int'(vcnt) + 1 >= PAT_LEN) && (cand == PAT);
  assign k_last = (k == KW'(Y_WIN - 1));

  always_ff @(posedge clk) begin
    if (!resetn) state <= RST;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RST:     state_next = F_PULSE;
      F_PULSE: state_next = SEARCH;
      SEARCH:  if (match) state_next = WAIT_Y;
      WAIT_Y: begin
        if (bus.y)       state_next = GRANT;
        else if (k_last) state_next = DENY;
      end
      GRANT, DENY: if (bus.rearm) state_next = SEARCH;
      default: state_next = RST;
    endcase
  end

  always_comb begin
    bus.f       = (state == F_PULSE);
    bus.g       = (state == WAIT_Y) || (state == GRANT);
    bus.granted = (state == GRANT);
    bus.denied  = (state == DENY);
  end

  assign bus.grant_count = cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      hist <= '0;
      vcnt <= '0;
      k    <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        F_PULSE: begin
          hist <= '0;
          vcnt <= '0;
        end
        SEARCH: begin
          if (match) begin
            k <= '0;
          end else begin
            hist <= cand[HW-1:0];
            if (int'(vcnt) < PAT_LEN) vcnt <= vcnt + VW'(1);
          end
        end
        WAIT_Y: begin
          if (!bus.y && !k_last) k <= k + KW'(1);
          if (bus.y && cnt != '1) cnt <= cnt + CNT_W'(1);
        end
        GRANT, DENY: begin
          if (bus.rearm) begin
            hist <= '0;
            vcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_q2b_seq_monitor.sv
// Directed bench for q2b_seq_monitor: default instance plus a 4-bit pattern,
// 3-cycle window instance, checked through an expected-response queue.
module tb_q2b_seq_monitor;
  localparam int S_RST = 0, S_F = 1, S_SR = 2, S_WY = 3, S_GR = 4, S_DN = 5;

  typedef struct {
    bit    sel;
    logic  f, g, gr, dn;
    int    cnt;
    string nm;
  } exp_t;

  logic clk = 1'b0;
  logic rn_a = 1'b0;
  logic rn_b = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t e;

  q2b_seq_monitor_if #(.CNT_W(8)) bus_a();
  q2b_seq_monitor_if #(.CNT_W(8)) bus_b();

  q2b_seq_monitor dut_a (.clk(clk), .resetn(rn_a), .bus(bus_a));
  q2b_seq_monitor #(.PAT_LEN(4), .PAT(4'b1101), .Y_WIN(3), .CNT_W(8))
    dut_b (.clk(clk), .resetn(rn_b), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic cyc(input bit sel, input logic rn, input logic xi, input logic yi,
                     input logic ri, input int st, input int ecnt, input string nm);
    exp_t t;
    if (sel) begin
      rn_b = rn; bus_b.x = xi; bus_b.y = yi; bus_b.rearm = ri;
    end else begin
      rn_a = rn; bus_a.x = xi; bus_a.y = yi; bus_a.rearm = ri;
    end
    @(posedge clk);
    #1;
    t.sel = sel;
    t.f   = (st == S_F);
    t.g   = (st == S_WY) || (st == S_GR);
    t.gr  = (st == S_GR);
    t.dn  = (st == S_DN);
    t.cnt = ecnt;
    t.nm  = nm;
    sb.push_back(t);
  endtask

  initial begin
    logic af, ag, agr, adn;
    int   acnt;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.sel) begin
          af = bus_b.f; ag = bus_b.g; agr = bus_b.granted; adn = bus_b.denied;
          acnt = int'(bus_b.grant_count);
        end else begin
          af = bus_a.f; ag = bus_a.g; agr = bus_a.granted; adn = bus_a.denied;
          acnt = int'(bus_a.grant_count);
        end
        total++;
        if ({af, ag, agr, adn} !== {e.f, e.g, e.gr, e.dn} || acnt != e.cnt) begin
          bad++;
          $display("FAIL %s: got f=%b g=%b granted=%b denied=%b cnt=%0d, want f=%b g=%b granted=%b denied=%b cnt=%0d",
                   e.nm, af, ag, agr, adn, acnt, e.f, e.g, e.gr, e.dn, e.cnt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    bus_a.x = 0; bus_a.y = 0; bus_a.rearm = 0;
    bus_b.x = 0; bus_b.y = 0; bus_b.rearm = 0;

    // reset and start pulse; x=1 during F_PULSE must be ignored
    cyc(0, 0, 0, 0, 0, S_RST, 0, "rst0");
    cyc(0, 0, 0, 0, 0, S_RST, 0, "rst1");
    cyc(0, 1, 0, 0, 0, S_F,   0, "f_pulse");
    cyc(0, 1, 1, 0, 0, S_SR,  0, "f_once");
    cyc(0, 1, 0, 0, 0, S_SR,  0, "srch0");
    cyc(0, 1, 1, 0, 0, S_SR,  0, "no_early");
    cyc(0, 1, 0, 0, 0, S_SR,  0, "srch2");
    cyc(0, 1, 1, 0, 0, S_WY,  0, "match");
    cyc(0, 1, 0, 0, 1, S_WY,  0, "wy_rearm_ign");
    cyc(0, 1, 0, 1, 0, S_GR,  1, "grant");
    cyc(0, 1, 1, 0, 0, S_GR,  1, "grant_hold0");
    cyc(0, 1, 0, 0, 0, S_GR,  1, "grant_hold1");

    // rearm then deny path
    cyc(0, 1, 0, 0, 1, S_SR,  1, "rearm_gr");
    cyc(0, 1, 1, 0, 0, S_SR,  1, "d_x1");
    cyc(0, 1, 0, 0, 0, S_SR,  1, "d_x0");
    cyc(0, 1, 1, 0, 0, S_WY,  1, "d_match");
    cyc(0, 1, 0, 0, 0, S_WY,  1, "d_wy1");
    cyc(0, 1, 0, 0, 0, S_DN,  1, "deny");
    cyc(0, 1, 1, 1, 0, S_DN,  1, "deny_hold0");
    cyc(0, 1, 0, 1, 0, S_DN,  1, "deny_hold1");

    // overlapping matches
    cyc(0, 1, 0, 0, 1, S_SR,  1, "rearm_dn");
    cyc(0, 1, 1, 0, 0, S_SR,  1, "ov1_1");
    cyc(0, 1, 1, 0, 0, S_SR,  1, "ov1_2");
    cyc(0, 1, 0, 0, 0, S_SR,  1, "ov1_3");
    cyc(0, 1, 1, 0, 0, S_WY,  1, "ov1_match");
    cyc(0, 1, 0, 1, 0, S_GR,  2, "ov1_grant");
    cyc(0, 1, 0, 0, 1, S_SR,  2, "ov2_rearm");
    cyc(0, 1, 1, 0, 0, S_SR,  2, "ov2_1");
    cyc(0, 1, 0, 0, 0, S_SR,  2, "ov2_2");
    cyc(0, 1, 0, 0, 0, S_SR,  2, "ov2_3");
    cyc(0, 1, 1, 0, 0, S_SR,  2, "ov2_4");
    cyc(0, 1, 0, 0, 0, S_SR,  2, "ov2_5");
    cyc(0, 1, 1, 0, 0, S_WY,  2, "ov2_match");
    cyc(0, 1, 0, 0, 0, S_WY,  2, "ov2_wy");
    cyc(0, 1, 0, 0, 0, S_DN,  2, "ov2_deny");

    // repeated grants drive the counter into saturation
    c = 2;
    for (int i = 0; i < 300; i++) begin
      cyc(0, 1, 0, 0, 1, S_SR, c, "loop_rearm");
      cyc(0, 1, 1, 0, 0, S_SR, c, "loop_x1");
      cyc(0, 1, 0, 0, 0, S_SR, c, "loop_x0");
      cyc(0, 1, 1, 0, 0, S_WY, c, "loop_match");
      c = (c < 255) ? c + 1 : 255;
      cyc(0, 1, 0, 1, 0, S_GR, c, "loop_grant");
    end
    cyc(0, 1, 0, 0, 0, S_GR, 255, "sat_hold");

    // reset in the middle of the confirm window
    cyc(0, 1, 0, 0, 1, S_SR,  255, "mr_rearm");
    cyc(0, 1, 1, 0, 0, S_SR,  255, "mr_x1");
    cyc(0, 1, 0, 0, 0, S_SR,  255, "mr_x0");
    cyc(0, 1, 1, 0, 0, S_WY,  255, "mr_match");
    cyc(0, 0, 0, 1, 1, S_RST, 0,   "mr_reset");
    cyc(0, 1, 0, 0, 0, S_F,   0,   "mr_f");
    cyc(0, 1, 0, 0, 0, S_SR,  0,   "mr_search");

    // 4-bit pattern, 3-cycle window instance
    cyc(1, 0, 0, 0, 0, S_RST, 0, "b_rst");
    cyc(1, 1, 0, 0, 0, S_F,   0, "b_f");
    cyc(1, 1, 0, 0, 0, S_SR,  0, "b_search");
    cyc(1, 1, 1, 0, 0, S_SR,  0, "b_x1");
    cyc(1, 1, 1, 0, 0, S_SR,  0, "b_x2");
    cyc(1, 1, 0, 0, 0, S_SR,  0, "b_x3");
    cyc(1, 1, 1, 0, 0, S_WY,  0, "b_match");
    cyc(1, 1, 0, 0, 0, S_WY,  0, "b_wy1");
    cyc(1, 1, 0, 0, 0, S_WY,  0, "b_wy2");
    cyc(1, 1, 0, 1, 0, S_GR,  1, "b_grant_k2");
    cyc(1, 1, 0, 0, 1, S_SR,  1, "b_rearm");
    cyc(1, 1, 1, 0, 0, S_SR,  1, "b2_x1");
    cyc(1, 1, 1, 0, 0, S_SR,  1, "b2_x2");
    cyc(1, 1, 0, 0, 0, S_SR,  1, "b2_x3");
    cyc(1, 1, 1, 0, 0, S_WY,  1, "b2_match");
    cyc(1, 1, 0, 0, 0, S_WY,  1, "b2_wy1");
    cyc(1, 1, 0, 0, 0, S_WY,  1, "b2_wy2");
    cyc(1, 1, 0, 0, 0, S_DN,  1, "b2_deny");

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
